// File: rtl/chacha20_poly1305_pkg.sv
// Shared definitions for the ChaCha20-Poly1305 AEAD core.
// Contents: the formatter FSM state encoding, the segment-type codes, the block
// and length widths, and a helper that builds a byte-keep mask from a byte count.
package chacha20_poly1305_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned LEN_W     = 64;
    localparam int unsigned BYTES_W   = 5;

    localparam logic TYPE_AAD = 1'b0;
    localparam logic TYPE_CT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAad  = 3'd1,
        StCt   = 3'd2,
        StLen  = 3'd3,
        StErr  = 3'd4
    } fmt_state_e;

    // Byte i of the mask is all-ones when i < nbytes. Counts above 16 saturate
    // to a full mask; such words are rejected as errors before the mask is used.
    function automatic logic [BLK_W-1:0] keep_mask(input logic [BYTES_W-1:0] nbytes);
        logic [BLK_W-1:0] m;
        m = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (BYTES_W'(i) < nbytes) begin
                m[8*i +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/aead_mac_data_formatter_if.sv
// Stream bundle between the AEAD segment source, the MAC formatter and the
// Poly1305 engine.
//   in_*  : AAD/CT word stream into the formatter (valid/ready)
//   blk_* : Poly1305 block stream out of the formatter (valid/ready)
// Modports: slave = formatter view, master = source/sink view.
interface aead_mac_data_formatter_if;
    import chacha20_poly1305_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BLK_W-1:0]     in_data;
    logic [BYTES_W-1:0]   in_bytes;
    logic                 in_last;
    logic                 in_type;

    logic                 blk_valid;
    logic                 blk_ready;
    logic [BLK_W-1:0]     blk_data;
    logic                 blk_final;

    modport slave (
        input  in_valid, in_data, in_bytes, in_last, in_type, blk_ready,
        output in_ready, blk_valid, blk_data, blk_final
    );

    modport master (
        output in_valid, in_data, in_bytes, in_last, in_type, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_final
    );

endinterface

// File: rtl/aead_mac_data_formatter.sv
// Poly1305 message formatter for the ChaCha20-Poly1305 AEAD core.
// Takes the AAD segment then the CT segment as 128-bit words, zero-pads each
// word past its valid bytes, and finishes with a length block
// {ct_len, aad_len} (64-bit little-endian each) flagged by blk_final.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : begin a new message (aborts any message in progress)
//   bus          : in_* word stream and blk_* block stream (slave modport)
//   busy         : FSM not idle
//   done         : one-cycle pulse after the length block is taken
//   error        : sticky protocol error, cleared by start or reset
module aead_mac_data_formatter
    import chacha20_poly1305_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    aead_mac_data_formatter_if.slave     bus,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    fmt_state_e         state_q, state_d;
    logic               blk_valid_q, blk_valid_d;
    logic [BLK_W-1:0]   blk_data_q, blk_data_d;
    logic               blk_final_q, blk_final_d;
    logic [LEN_W-1:0]   aad_len_q, aad_len_d;
    logic [LEN_W-1:0]   ct_len_q, ct_len_d;
    logic               error_q, error_d;
    logic               done_q, done_d;

    logic               out_free;
    logic               in_ready;
    logic               in_acc;
    logic               blk_hs;
    logic               word_err;
    logic               exp_type;

    // Output register can take a new block now, or drains on this edge.
    assign out_free = !blk_valid_q || bus.blk_ready;
    assign in_ready = ((state_q == StAad) || (state_q == StCt)) && out_free;
    assign in_acc   = bus.in_valid && in_ready;
    assign blk_hs   = blk_valid_q && bus.blk_ready;
    assign exp_type = (state_q == StCt) ? TYPE_CT : TYPE_AAD;

    always_comb begin
        state_d     = state_q;
        blk_valid_d = blk_valid_q;
        blk_data_d  = blk_data_q;
        blk_final_d = blk_final_q;
        aad_len_d   = aad_len_q;
        ct_len_d    = ct_len_q;
        error_d     = error_q;
        done_d      = 1'b0;
        word_err    = 1'b0;

        if (blk_hs) begin
            blk_valid_d = 1'b0;
        end

        if (start) begin
            // Abort: a coinciding input word is dropped, a pending block is
            // withdrawn, and a coinciding final handshake does not report done.
            state_d     = StAad;
            blk_valid_d = 1'b0;
            aad_len_d   = '0;
            ct_len_d    = '0;
            error_d     = 1'b0;
        end else begin
            unique case (state_q)
                StAad, StCt: begin
                    if (in_acc) begin
                        word_err = (bus.in_type != exp_type) ||
                                   (bus.in_bytes > BYTES_W'(BLK_BYTES)) ||
                                   ((bus.in_bytes != BYTES_W'(BLK_BYTES)) && !bus.in_last);
                        if (word_err) begin
                            error_d = 1'b1;
                            state_d = StErr;
                        end else begin
                            // Zero-byte words only mark an empty segment end.
                            if (bus.in_bytes != '0) begin
                                blk_valid_d = 1'b1;
                                blk_data_d  = bus.in_data & keep_mask(bus.in_bytes);
                                blk_final_d = 1'b0;
                            end
                            if (state_q == StAad) begin
                                aad_len_d = aad_len_q + LEN_W'(bus.in_bytes);
                                if (bus.in_last) begin
                                    state_d = StCt;
                                end
                            end else begin
                                ct_len_d = ct_len_q + LEN_W'(bus.in_bytes);
                                if (bus.in_last) begin
                                    state_d = StLen;
                                end
                            end
                        end
                    end
                end
                StLen: begin
                    // blk_valid & blk_final only ever means the length block is
                    // already loaded; otherwise load it once the register frees.
                    if (blk_valid_q && blk_final_q) begin
                        if (bus.blk_ready) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else if (out_free) begin
                        blk_valid_d = 1'b1;
                        blk_data_d  = {ct_len_q, aad_len_q};
                        blk_final_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            blk_valid_q <= 1'b0;
            blk_data_q  <= '0;
            blk_final_q <= 1'b0;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_valid_q <= blk_valid_d;
            blk_data_q  <= blk_data_d;
            blk_final_q <= blk_final_d;
            aad_len_q   <= aad_len_d;
            ct_len_q    <= ct_len_d;
            error_q     <= error_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_data  = blk_data_q;
    assign bus.blk_final = blk_final_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_aead_mac_data_formatter.sv
// Self-checking bench for aead_mac_data_formatter: table-driven messages plus
// hand-written backpressure, error and abort sequences.
module tb_aead_mac_data_formatter;
    import chacha20_poly1305_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic error;

    aead_mac_data_formatter_if bus ();

    aead_mac_data_formatter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   nbytes;
        logic         last;
        logic         typ;
        logic         emit;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] got_data[$];
    logic         got_final[$];
    int           done_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    // Block handshakes and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.blk_valid && bus.blk_ready) begin
            got_data.push_back(bus.blk_data);
            got_final.push_back(bus.blk_final);
        end
        if (done) done_cnt++;
    end

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Callers enter and leave these tasks 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_word(input string name, input logic [127:0] d, input logic [4:0] nb,
                             input logic last, input logic typ);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_bytes = nb;
        bus.in_last  = last;
        bus.in_type  = typ;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", name);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done timeout got no pulse expected pulse", name);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs the message in vecs after a start pulse and checks every block.
    task automatic run_msg(input string name, input logic [127:0] exp_len);
        logic [127:0] e[$];
        int d0;
        got_data.delete();
        got_final.delete();
        pulse_start();
        d0 = done_cnt;
        foreach (vecs[i]) begin
            send_word(name, vecs[i].data, vecs[i].nbytes, vecs[i].last, vecs[i].typ);
            if (vecs[i].emit) e.push_back(vecs[i].exp);
        end
        e.push_back(exp_len);
        wait_done(name, d0);
        check_int({name, " blk count"}, got_data.size(), e.size());
        for (int i = 0; i < e.size() && i < got_data.size(); i++) begin
            check_vec($sformatf("%s blk%0d data", name, i), got_data[i], e[i]);
            check_bit($sformatf("%s blk%0d final", name, i), got_final[i], i == e.size() - 1);
        end
        check_int({name, " done pulses"}, done_cnt - d0, 1);
        check_bit({name, " busy after done"}, busy, 1'b0);
        check_bit({name, " error"}, error, 1'b0);
    endtask

    task automatic fill_rfc();
        vecs.delete();
        vecs.push_back('{128'hDEADBEEF_C7C6C5C4_C3C2C1C0_53525150, 5'd12, 1'b1, TYPE_AAD, 1'b1,
                         128'h00000000_C7C6C5C4_C3C2C1C0_53525150});
        for (int k = 0; k < 7; k++) begin
            vecs.push_back('{{4{32'hC7000000 + 32'(k)}}, 5'd16, 1'b0, TYPE_CT, 1'b1,
                             {4{32'hC7000000 + 32'(k)}}});
        end
        vecs.push_back('{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF1D64, 5'd2, 1'b1, TYPE_CT, 1'b1,
                         128'h1D64});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] hold;
        int d0;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_bytes  = '0;
        bus.in_last   = 1'b0;
        bus.in_type   = 1'b0;
        bus.blk_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset in_ready", bus.in_ready, 1'b0);
        check_bit("reset blk_valid", bus.blk_valid, 1'b0);
        check_vec("reset blk_data", bus.blk_data, 128'h0);
        check_bit("reset blk_final", bus.blk_final, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset done", done, 1'b0);
        check_bit("reset error", error, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_bit("idle in_ready", bus.in_ready, 1'b0);

        // RFC 8439 2.8.2 shape: 12 AAD bytes, 114 CT bytes.
        fill_rfc();
        run_msg("rfc", {64'h72, 64'hC});

        vecs.delete();
        vecs.push_back('{128'h0, 5'd0, 1'b1, TYPE_AAD, 1'b0, 128'h0});
        vecs.push_back('{{4{32'h5A5A0001}}, 5'd16, 1'b1, TYPE_CT, 1'b1, {4{32'h5A5A0001}}});
        run_msg("empty_aad", {64'h10, 64'h0});

        vecs.delete();
        vecs.push_back('{128'h0, 5'd0, 1'b1, TYPE_AAD, 1'b0, 128'h0});
        vecs.push_back('{128'h0, 5'd0, 1'b1, TYPE_CT, 1'b0, 128'h0});
        run_msg("both_empty", 128'h0);

        // Backpressure: stall the sink for 5 cycles mid-stream.
        vecs.delete();
        vecs.push_back('{{4{32'hAA000000}}, 5'd16, 1'b1, TYPE_AAD, 1'b1, {4{32'hAA000000}}});
        for (int k = 1; k <= 5; k++) begin
            vecs.push_back('{{4{32'hBB000000 + 32'(k)}}, 5'd16, k == 5, TYPE_CT, 1'b1,
                             {4{32'hBB000000 + 32'(k)}}});
        end
        got_data.delete();
        got_final.delete();
        fork
            run_msg("bp", {64'h50, 64'h10});
            begin
                n = 0;
                while (got_data.size() < 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check_int("bp reached stall point", got_data.size() >= 2 ? 1 : 0, 1);
                @(posedge clk);
                #1;
                bus.blk_ready = 1'b0;
                hold = bus.blk_data;
                check_bit("bp blk_valid held", bus.blk_valid, 1'b1);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check_bit($sformatf("bp in_ready c%0d", c), bus.in_ready, 1'b0);
                    check_vec($sformatf("bp blk_data c%0d", c), bus.blk_data, hold);
                end
                @(posedge clk);
                #1;
                bus.blk_ready = 1'b1;
            end
        join

        // Wrong segment type during AAD.
        got_data.delete();
        pulse_start();
        send_word("err_type", {4{32'h11111111}}, 5'd16, 1'b0, TYPE_CT);
        check_bit("err_type error", error, 1'b1);
        check_bit("err_type in_ready", bus.in_ready, 1'b0);
        check_bit("err_type busy", busy, 1'b1);
        check_bit("err_type no block", bus.blk_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_bit("err_type sticky", error, 1'b1);

        // Short word without in_last.
        pulse_start();
        check_bit("start clears error", error, 1'b0);
        send_word("err_short", {4{32'h22222222}}, 5'd7, 1'b0, TYPE_AAD);
        check_bit("err_short error", error, 1'b1);
        check_bit("err_short in_ready", bus.in_ready, 1'b0);
        check_bit("err_short busy", busy, 1'b1);
        check_int("err blocks emitted", got_data.size(), 0);

        fill_rfc();
        run_msg("rfc_after_err", {64'h72, 64'hC});

        // Abort with a stalled block pending.
        got_data.delete();
        got_final.delete();
        bus.blk_ready = 1'b0;
        pulse_start();
        d0 = done_cnt;
        send_word("abort", {4{32'h33333333}}, 5'd16, 1'b0, TYPE_AAD);
        check_bit("abort pending", bus.blk_valid, 1'b1);
        pulse_start();
        check_bit("abort blk_valid dropped", bus.blk_valid, 1'b0);
        bus.blk_ready = 1'b1;
        send_word("abort", 128'h0, 5'd0, 1'b1, TYPE_AAD);
        send_word("abort", 128'h0, 5'd0, 1'b1, TYPE_CT);
        wait_done("abort", d0);
        check_int("abort blk count", got_data.size(), 1);
        if (got_data.size() > 0) begin
            check_vec("abort counters cleared", got_data[0], 128'h0);
            check_bit("abort final", got_final[0], 1'b1);
        end
        check_int("abort done pulses", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
